// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a serial kernel+frame byte stream into stride-1 4x4 windows for the conv MAC.
// Optional cross-channel partial-sum buffer is enabled with `define CONV_ACC_EN.
module conv_window_feeder #(
    parameter int lenOfInput  = 8,
    parameter int lenOfOutput = 25,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int NUM_CH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kern_load,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [lenOfInput-1:0]  in_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [16*lenOfInput-1:0]      win_data,
    output logic [16*lenOfInput-1:0]      kern_data,
    output logic signed [lenOfOutput-1:0] last_result,
    input  logic signed [lenOfOutput-1:0] conv_result,
    output logic                          win_last_ch,
    output logic                          frame_done,
    output logic                          busy
);
    localparam int NWIN = (IMG_H - 3) * (IMG_W - 3);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int L    = lenOfInput;

    typedef enum logic [1:0] {IDLE, LOAD_K, FRAME, DONE} state_t;

    state_t         state;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [3:0]     kidx;
    logic [WW-1:0]  widx;
    logic           pix_done;

    logic signed [L-1:0] lb0 [IMG_W];
    logic signed [L-1:0] lb1 [IMG_W];
    logic signed [L-1:0] lb2 [IMG_W];
    logic [16*L-1:0]     sw_p0;
    logic [16*L-1:0]     sw_nxt;

    logic pix_acc;
    logic win_hs;
    logic win_gen;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            LOAD_K:  in_ready = 1'b1;
            FRAME:   in_ready = !pix_done && (!win_valid || win_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign pix_acc = in_valid && in_ready && (state == FRAME);
    assign win_hs  = win_valid && win_ready;
    assign win_gen = pix_acc && (row >= RW'(3)) && (col >= CW'(3));
    assign busy    = (state != IDLE);

    // Window slot (4r+c): columns move left, the new right column is the three buffered rows plus the incoming pixel.
    always_comb begin
        sw_nxt = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                sw_nxt[(4*r+c)*L +: L] = sw_p0[(4*r+c+1)*L +: L];
            end
        end
        sw_nxt[3*L  +: L] = lb0[col];
        sw_nxt[7*L  +: L] = lb1[col];
        sw_nxt[11*L +: L] = lb2[col];
        sw_nxt[15*L +: L] = in_data;
    end

    // Stage p0: line buffers and shift window, data only
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb0[col] <= lb1[col];
            lb1[col] <= lb2[col];
            lb2[col] <= in_data;
            sw_p0    <= sw_nxt;
        end
    end

    // Stage p1: control FSM, kernel register and the presented window
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            kidx       <= '0;
            widx       <= '0;
            pix_done   <= 1'b0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            kern_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (kern_load) state <= LOAD_K;
                end
                LOAD_K: begin
                    if (in_valid) begin
                        kern_data[kidx*L +: L] <= in_data;
                        kidx <= kidx + 4'd1;
                        if (kidx == 4'd15) state <= FRAME;
                    end
                end
                FRAME: begin
                    if (pix_acc) begin
                        if (col == CW'(IMG_W - 1)) begin
                            col <= '0;
                            if (row == RW'(IMG_H - 1)) pix_done <= 1'b1;
                            else                       row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    // A new window can only be generated when the old one is gone or leaving this cycle.
                    if (win_gen) begin
                        win_valid <= 1'b1;
                        win_data  <= sw_nxt;
                    end else if (win_hs) begin
                        win_valid <= 1'b0;
                    end
                    if (win_hs) begin
                        if (widx == WW'(NWIN - 1)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    row      <= '0;
                    col      <= '0;
                    widx     <= '0;
                    pix_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_ACC_EN
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CHW-1:0]               ch;
    logic signed [lenOfOutput-1:0] psum [NWIN];

    always_ff @(posedge clk) begin
        if (rst) begin
            ch <= '0;
            for (int i = 0; i < NWIN; i++) psum[i] <= '0;
        end else begin
            if (state == DONE) ch <= (ch == CHW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
            if (win_hs) psum[widx] <= conv_result;
        end
    end

    assign last_result = (ch == '0) ? '0 : psum[widx];
    assign win_last_ch = win_valid && (ch == CHW'(NUM_CH - 1));
`else
    localparam int unused_num_ch = NUM_CH;
    logic unused_conv;

    assign unused_conv = ^conv_result;
    assign last_result = '0;
    assign win_last_ch = win_valid;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: vector table of frames plus reset/stall/abort sequences, checked against a window model.
// Expectations follow CONV_ACC_EN the same way the design does.
module tb_conv_window_feeder;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NCH  = 2;
    localparam int NWIN = (H - 3) * (W - 3);
    localparam int NPIX = W * H;

    logic               clk = 1'b0;
    logic               rst;
    logic               kern_load;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               win_valid;
    logic               win_ready;
    logic [127:0]       win_data;
    logic [127:0]       kern_data;
    logic signed [24:0] last_result;
    logic signed [24:0] conv_result;
    logic               win_last_ch;
    logic               frame_done;
    logic               busy;

    conv_window_feeder #(
        .lenOfInput(8), .lenOfOutput(25), .IMG_W(W), .IMG_H(H), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .rst(rst), .kern_load(kern_load), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .kern_data(kern_data),
        .last_result(last_result), .conv_result(conv_result),
        .win_last_ch(win_last_ch), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix_mode;   // 0: pixel 8r+c with kernel 1..16, 1: random frame and kernel
        int rdy_mode;   // 0: always ready, 1: hold off window 1 for 5 cycles, 2: random
        int gap;        // 1: random bubbles on in_valid
        bit kmid;       // pulse kern_load in the middle of the frame
        int f00, f33, l00, l33;  // first/last window corners, -1 = model only
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] frm [H][W];
    logic [7:0] kern_v [16];
    int         ntests = 0;
    int         nfail  = 0;
    int         exp_ch = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_win(input int n);
        logic [127:0] v;
        int wr, wc;
        wr = n / (W - 3);
        wc = n % (W - 3);
        v  = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(4*r+c)*8 +: 8] = frm[wr+r][wc+c];
        return v;
    endfunction

    function automatic logic [127:0] kpack();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = kern_v[k];
        return v;
    endfunction

    function automatic int exp_lr(input int n);
`ifdef CONV_ACC_EN
        return (exp_ch == 0) ? 0 : 1000 + n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic int exp_lc();
`ifdef CONV_ACC_EN
        return (exp_ch == NCH - 1) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frm[r][c] = (mode == 0) ? 8'(8*r + c) : 8'($urandom);
        for (int k = 0; k < 16; k++)
            kern_v[k] = (mode == 0) ? 8'(k + 1) : 8'($urandom);
    endtask

    task automatic load_kernel();
        kern_load = 1'b1;
        tick();
        kern_load = 1'b0;
        chk("busy_after_kern_load", 128'(busy), 128'(1));
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = kern_v[k];
            tick();
        end
        in_valid = 1'b0;
        chk("kern_data_loaded", kern_data, kpack());
    endtask

    task automatic run_frame(input vec_t v);
        int pix = 0, nwin = 0, stall = 0, cyc = 0, last_hs = -10;
        bit seen_done = 1'b0;
        load_kernel();
        while (!seen_done && cyc < 3000) begin
            case (v.rdy_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = !(win_valid && nwin == 1 && stall < 5);
                default: win_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (pix < NPIX && (v.gap == 0 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = frm[pix / W][pix % W];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            kern_load   = v.kmid && (pix == 20);
            conv_result = 25'(1000 + nwin);
            #1;
            if (frame_done) begin
                chk("frame_done_latency", 128'(cyc), 128'(last_hs + 1));
                chk("window_count", 128'(nwin), 128'(NWIN));
                seen_done = 1'b1;
            end
            if (win_valid && !win_ready) begin
                chk("stall_in_ready", 128'(in_ready), 128'(0));
                chk("stall_win_data", win_data, exp_win(nwin));
                stall++;
            end
            if (win_valid && win_ready && nwin < NWIN) begin
                chk("win_data", win_data, exp_win(nwin));
                chk("kern_data_hold", kern_data, kpack());
                chk("last_result", 128'(last_result), 128'(exp_lr(nwin)));
                chk("win_last_ch", 128'(win_last_ch), 128'(exp_lc()));
                if (nwin == 0 && v.f00 >= 0) begin
                    chk("first_data00", 128'(win_data[7:0]), 128'(v.f00));
                    chk("first_data33", 128'(win_data[127:120]), 128'(v.f33));
                end
                if (nwin == NWIN - 1 && v.l00 >= 0) begin
                    chk("last_data00", 128'(win_data[7:0]), 128'(v.l00));
                    chk("last_data33", 128'(win_data[127:120]), 128'(v.l33));
                end
                if (nwin == NWIN - 1) last_hs = cyc;
                nwin++;
            end
            if (in_valid && in_ready) pix++;
            @(posedge clk);
            #1;
            cyc++;
        end
        kern_load = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        if (!seen_done) begin
            ntests++;
            nfail++;
            $display("FAIL frame_timeout: got %0d windows, frame_done never seen", nwin);
        end
        if (v.rdy_mode == 1) chk("stall_cycles", 128'(stall), 128'(5));
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("frame_done_pulse", 128'(frame_done), 128'(0));
`ifdef CONV_ACC_EN
        exp_ch = (exp_ch + 1) % NCH;
`endif
    endtask

    initial begin
        rst = 1'b1; kern_load = 1'b0; in_valid = 1'b0; in_data = '0;
        win_ready = 1'b0; conv_result = '0;
        vecs[0] = '{0, 0, 0, 1'b0, 0, 27, 36, 63};
        vecs[1] = '{0, 1, 0, 1'b0, 0, 27, 36, 63};
        vecs[2] = '{0, 0, 0, 1'b1, 0, 27, 36, 63};
        vecs[3] = '{0, 0, 0, 1'b0, 0, 27, 36, 63};
        vecs[4] = '{1, 2, 1, 1'b0, -1, -1, -1, -1};
        vecs[5] = '{1, 0, 1, 1'b1, -1, -1, -1, -1};

        // reset state, and a beat offered in IDLE is refused
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd55;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_win_valid", 128'(win_valid), 128'(0));
        chk("rst_win_data", win_data, 128'(0));
        chk("rst_kern_data", kern_data, 128'(0));
        chk("rst_last_result", 128'(last_result), 128'(0));
        chk("rst_win_last_ch", 128'(win_last_ch), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        tick();
        chk("idle_beat_refused", 128'(busy), 128'(0));
        in_valid = 1'b0;

        // reset in the middle of a kernel load
        fill(0);
        kern_load = 1'b1;
        tick();
        kern_load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = kern_v[k];
            tick();
        end
        chk("partial_load_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midload_rst_busy", 128'(busy), 128'(0));
        chk("midload_rst_in_ready", 128'(in_ready), 128'(0));
        chk("midload_rst_kern_data", kern_data, 128'(0));
        chk("midload_rst_win_valid", 128'(win_valid), 128'(0));

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].pix_mode);
            run_frame(vecs[i]);
        end

        // abort a frame part way, then a clean frame must follow from channel 0
        fill(0);
        load_kernel();
        win_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            in_valid = 1'b1;
            in_data  = frm[p / W][p % W];
            tick();
        end
        in_valid = 1'b0;
        chk("midframe_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midframe_rst_busy", 128'(busy), 128'(0));
        chk("midframe_rst_win_valid", 128'(win_valid), 128'(0));
        chk("midframe_rst_last_result", 128'(last_result), 128'(0));
        exp_ch = 0;
        run_frame(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
